// File: rtl/minmax_tree_scheduler.sv
// Round-robin front end for one shared, start-gated min/max comparator tree.
// Tracks a valid/ID token per tree stage and returns each result to its requester.
module minmax_tree_scheduler #(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned NUM_INPUTS = 4,
  parameter  int unsigned WIDTH      = 7,
  localparam int unsigned LATENCY    = $clog2(NUM_INPUTS),
  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  io_req_valid,
  output logic [NUM_REQ-1:0]                  io_req_ready,
  input  logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0] io_req_data,
  output logic                                io_tree_start,
  output logic [NUM_INPUTS*WIDTH-1:0]         io_tree_inputs,
  input  logic [WIDTH-1:0]                    io_tree_result,
  output logic                                io_resp_valid,
  input  logic                                io_resp_ready,
  output logic [ID_W-1:0]                     io_resp_id,
  output logic [WIDTH-1:0]                    io_resp_data,
  output logic                                io_busy
);

  localparam int unsigned VEC_W = NUM_INPUTS * WIDTH;

  logic [LATENCY-1:0] tok_v_q, tok_v_d;
  logic [ID_W-1:0]    tok_id_q [LATENCY];
  logic [ID_W-1:0]    tok_id_d [LATENCY];
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic            any_req_c;
  logic            stall_c;
  logic            advance_c;
  logic            grant_vld_c;
  logic            grant_found_c;
  logic [ID_W-1:0] grant_id_c;

  // Round-robin scan: first valid requester at offset 0, 1, ... from rr_ptr.
  always_comb begin
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (!grant_found_c && io_req_valid[r] &&
            (((32'(rr_ptr_q) + i) % NUM_REQ) == r)) begin
          grant_found_c = 1'b1;
          grant_id_c    = ID_W'(r);
        end
      end
    end
  end

  // The whole tree freezes while the tail result waits on the consumer.
  always_comb begin
    any_req_c   = |io_req_valid;
    stall_c     = tok_v_q[LATENCY-1] & ~io_resp_ready;
    advance_c   = ~reset & ~stall_c & (any_req_c | (|tok_v_q));
    grant_vld_c = advance_c & any_req_c & grant_found_c;
  end

  // Operand mux and ready decode; zeros are injected as bubbles.
  always_comb begin
    io_req_ready   = '0;
    io_tree_inputs = '0;
    if (grant_vld_c) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (grant_id_c == ID_W'(r)) begin
          io_req_ready[r] = 1'b1;
          io_tree_inputs  = io_req_data[r*VEC_W +: VEC_W];
        end
      end
    end
  end

  assign io_tree_start = advance_c;
  assign io_resp_valid = ~reset & tok_v_q[LATENCY-1];
  assign io_resp_id    = reset ? '0 : tok_id_q[LATENCY-1];
  assign io_resp_data  = io_tree_result;
  assign io_busy       = ~reset & (|tok_v_q);

  // Token shift register mirrors the tree stages; moves only with io_tree_start.
  always_comb begin
    tok_v_d  = tok_v_q;
    tok_id_d = tok_id_q;
    rr_ptr_d = rr_ptr_q;
    if (advance_c) begin
      tok_v_d[0]  = grant_vld_c;
      tok_id_d[0] = grant_id_c;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tok_v_d[i]  = tok_v_q[i-1];
        tok_id_d[i] = tok_id_q[i-1];
      end
      if (grant_vld_c) begin
        rr_ptr_d = (grant_id_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_c + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tok_v_q  <= '0;
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tok_id_q[i] <= '0;
      end
    end else begin
      tok_v_q  <= tok_v_d;
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tok_id_q[i] <= tok_id_d[i];
      end
    end
  end

endmodule
